serial_bus_slave_port: RTL and testbench

- Responder end of the bit-serial system bus; the counterpart to the master-side initiators started by m1_start and m2_start.
- Deserialises the mode bit, address and write data from the bus, then performs one access on a local memory.
- On a read, serialises the read data back to the master.
- Sits between the bus interconnect and a slave's local BRAM or register file.

---
 rtl/serial_bus_slave_port.sv | 208 ++++++++++++++++++++
 tb/tb_serial_bus_slave_port.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_slave_port.sv
// serial_bus_slave_port
// Responder end of the bit-serial system bus. A frame from the master is a
// mode bit (1 = write, 0 = read), ADDR_WIDTH address bits and, for writes,
// DATA_WIDTH data bits, all LSB first and one bit per mvalid=1 cycle. The
// block then performs a single access on a local memory. On a read it
// returns the data word serially to the master, LSB first.
//
// Ports
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   mvalid      : master-to-slave bit valid (stall when low)
//   mdata       : master-to-slave serial bit
//   sready      : high while idle; a new frame may start
//   svalid      : slave-to-master read bit valid
//   sdata       : slave-to-master serial read bit
//   mem_addr    : local memory address (assembled from the frame)
//   mem_wdata   : local memory write data (assembled from the frame)
//   mem_wen     : one-cycle write strobe
//   mem_ren     : one-cycle read strobe
//   mem_rdata   : local memory read data
//   mem_rvalid  : mem_rdata valid, only looked at while a read is pending
module serial_bus_slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mvalid,
    input  logic                  mdata,
    output logic                  sready,
    output logic                  svalid,
    output logic                  sdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_MEMWR = 3'd3,
        ST_MEMRD = 3'd4,
        ST_RDATA = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic                    mode_r;
    logic                    mode_nxt_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH-1:0]   addr_nxt_s;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH-1:0]   wdata_nxt_s;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [DATA_WIDTH-1:0]   shift_nxt_s;

    logic                    sready_r;
    logic                    sready_nxt_s;
    logic                    svalid_r;
    logic                    svalid_nxt_s;
    logic                    sdata_r;
    logic                    sdata_nxt_s;
    logic                    wen_r;
    logic                    wen_nxt_s;
    logic                    ren_r;
    logic                    ren_nxt_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, datapath next values and next registered outputs.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mode_nxt_s  = mode_r;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        shift_nxt_s = shift_r;

        case (state_r)
            ST_IDLE: begin
                if (mvalid) begin
                    mode_nxt_s  = mdata;
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (mvalid) begin
                    // LSB arrives first, so shift in from the top.
                    addr_nxt_s = {mdata, addr_r[ADDR_WIDTH-1:1]};
                    if (cnt_r == ADDR_LAST) begin
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = mode_r ? ST_WDATA : ST_MEMRD;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_WDATA: begin
                if (mvalid) begin
                    wdata_nxt_s = {mdata, wdata_r[DATA_WIDTH-1:1]};
                    if (cnt_r == DATA_LAST) begin
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = ST_MEMWR;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt_s = ST_WDATA;
                end
            end
            ST_MEMWR: begin
                state_nxt_s = ST_IDLE;
            end
            ST_MEMRD: begin
                // Sampled on the strobe cycle too, so zero-latency memory works.
                if (mem_rvalid) begin
                    shift_nxt_s = mem_rdata;
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_RDATA;
                end else begin
                    state_nxt_s = ST_MEMRD;
                end
            end
            ST_RDATA: begin
                if (cnt_r == DATA_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    shift_nxt_s = shift_r >> 1;
                end
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        sready_nxt_s = (state_nxt_s == ST_IDLE);
        svalid_nxt_s = (state_nxt_s == ST_RDATA);
        sdata_nxt_s  = (state_nxt_s == ST_RDATA) ? shift_nxt_s[0] : 1'b0;
        wen_nxt_s    = (state_nxt_s == ST_MEMWR);
        // Read strobe only on entry to MEMRD, not while waiting for data.
        ren_nxt_s    = (state_nxt_s == ST_MEMRD) && (state_r != ST_MEMRD);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= CNT_ZERO;
            mode_r   <= 1'b0;
            addr_r   <= {ADDR_WIDTH{1'b0}};
            wdata_r  <= {DATA_WIDTH{1'b0}};
            shift_r  <= {DATA_WIDTH{1'b0}};
            sready_r <= 1'b1;
            svalid_r <= 1'b0;
            sdata_r  <= 1'b0;
            wen_r    <= 1'b0;
            ren_r    <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            mode_r   <= mode_nxt_s;
            addr_r   <= addr_nxt_s;
            wdata_r  <= wdata_nxt_s;
            shift_r  <= shift_nxt_s;
            sready_r <= sready_nxt_s;
            svalid_r <= svalid_nxt_s;
            sdata_r  <= sdata_nxt_s;
            wen_r    <= wen_nxt_s;
            ren_r    <= ren_nxt_s;
        end
    end

    assign sready    = sready_r;
    assign svalid    = svalid_r;
    assign sdata     = sdata_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_wen   = wen_r;
    assign mem_ren   = ren_r;

endmodule

// File: tb/tb_serial_bus_slave_port.sv
// Self-checking bench for serial_bus_slave_port: table of directed frames,
// a reset-mid-frame sequence and randomized frames checked against a
// word-level memory reference.
module tb_serial_bus_slave_port;

    logic        clk;
    logic        rst;
    logic        mvalid;
    logic        mdata;
    logic        sready;
    logic        svalid;
    logic        sdata;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;

    serial_bus_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .mvalid     (mvalid),
        .mdata      (mdata),
        .sready     (sready),
        .svalid     (svalid),
        .sdata      (sdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory seen by the DUT, and the reference view of what it should hold.
    logic [7:0] bram    [0:4095];
    logic [7:0] ref_mem [0:4095];

    // Per-cycle observations.
    int          cyc = 0;
    int          wen_n = 0;
    int          wen_cyc = 0;
    logic [11:0] wen_a = 12'h000;
    logic [7:0]  wen_d = 8'h00;
    int          ren_n = 0;
    int          ren_cyc = 0;
    int          rv_cyc = 0;
    int          sv_n = 0;
    int          sv_first = 0;
    int          sv_last = 0;
    logic [7:0]  rx = 8'h00;
    int          cur_lat = 0;
    int          lat_cnt = 0;
    logic        pend = 1'b0;

    typedef struct {
        logic        mode;
        logic [11:0] addr;
        logic [7:0]  data;
        int          gap;
        int          lat;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl [0:7];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock, observe outputs, run the memory model.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_wen) begin
            wen_n++;
            wen_cyc = cyc;
            wen_a = mem_addr;
            wen_d = mem_wdata;
            bram[mem_addr] = mem_wdata;
        end
        if (mem_ren) begin
            ren_n++;
            ren_cyc = cyc;
            pend = 1'b1;
            lat_cnt = cur_lat;
        end
        if (svalid) begin
            if (sv_n == 0) sv_first = cyc;
            sv_last = cyc;
            rx = {sdata, rx[7:1]};
            sv_n++;
        end
        mem_rvalid = 1'b0;
        mem_rdata = 8'($urandom);
        if (pend) begin
            if (lat_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata = bram[mem_addr];
                pend = 1'b0;
                rv_cyc = cyc;
            end else begin
                lat_cnt--;
            end
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        int n;
        n = (gap > 0) ? int'($urandom_range(gap, 1)) : 0;
        for (int i = 0; i < n; i++) begin
            mvalid = 1'b0;
            mdata = 1'($urandom);
            step();
        end
        mvalid = 1'b1;
        mdata = b;
        step();
    endtask

    task automatic do_txn(input logic md, input logic [11:0] a, input logic [7:0] d,
                          input int gap, input int lat, input logic [7:0] exp_rd);
        int w0;
        int r0;
        int last;
        int k;
        w0 = wen_n;
        r0 = ren_n;
        sv_n = 0;
        rx = 8'h00;
        cur_lat = lat;
        send_bit(md, gap);
        for (int i = 0; i < 12; i++) send_bit(a[i], gap);
        if (md) begin
            for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        end
        last = cyc;
        mvalid = 1'b0;
        mdata = 1'b0;
        k = 0;
        while (sready !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("done_in_time", int'(k < 200), 1);
        if (md) begin
            chk("wen_count", wen_n - w0, 1);
            chk("wen_cycle", wen_cyc, last);
            chk("wen_addr", int'(wen_a), int'(a));
            chk("wen_data", int'(wen_d), int'(d));
            chk("wr_ren_count", ren_n - r0, 0);
            chk("wr_svalid_count", sv_n, 0);
            chk("wr_sready_cycle", cyc, last + 1);
            ref_mem[a] = d;
        end else begin
            chk("ren_count", ren_n - r0, 1);
            chk("ren_cycle", ren_cyc, last);
            chk("rd_wen_count", wen_n - w0, 0);
            chk("svalid_count", sv_n, 8);
            chk("svalid_first", sv_first, rv_cyc + 1);
            chk("svalid_span", sv_last - sv_first, 7);
            chk("rdata", int'(rx), int'(exp_rd));
            chk("rd_sready_cycle", cyc, sv_last + 1);
            chk("sdata_idle", int'(sdata), 0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sready"}, int'(sready), 1);
        chk({tag, "_svalid"}, int'(svalid), 0);
        chk({tag, "_sdata"}, int'(sdata), 0);
        chk({tag, "_wen"}, int'(mem_wen), 0);
        chk({tag, "_ren"}, int'(mem_ren), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_wdata"}, int'(mem_wdata), 0);
    endtask

    initial begin
        int w0;
        logic        md;
        logic [11:0] a;
        logic [7:0]  d;

        rst = 1'b1;
        mvalid = 1'b0;
        mdata = 1'b0;
        mem_rdata = 8'h00;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            bram[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        bram[12'h123] = 8'hA5;
        ref_mem[12'h123] = 8'hA5;
        bram[12'h001] = 8'h5A;
        ref_mem[12'h001] = 8'h5A;

        //            mode  addr     data   gap lat exp_rd
        tbl[0] = '{1'b1, 12'h0A5, 8'h3C, 0, 0, 8'h00};
        tbl[1] = '{1'b0, 12'h0A5, 8'h00, 0, 3, 8'h3C};
        tbl[2] = '{1'b0, 12'h123, 8'h00, 0, 0, 8'hA5};
        tbl[3] = '{1'b1, 12'hFFF, 8'hFF, 5, 0, 8'h00};
        tbl[4] = '{1'b0, 12'hFFF, 8'h00, 2, 1, 8'hFF};
        tbl[5] = '{1'b1, 12'h010, 8'h55, 0, 0, 8'h00};
        tbl[6] = '{1'b0, 12'h010, 8'h00, 0, 2, 8'h55};
        tbl[7] = '{1'b0, 12'h000, 8'h00, 1, 4, 8'h03};

        repeat (3) step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].mode, tbl[i].addr, tbl[i].data, tbl[i].gap, tbl[i].lat, tbl[i].exp_rd);
        end

        // Reset after the mode bit and 6 address bits of a write.
        w0 = wen_n;
        mvalid = 1'b1;
        mdata = 1'b1;
        step();
        for (int i = 0; i < 6; i++) step();
        chk("pre_rst_addr_nonzero", int'(mem_addr != 12'h000), 1);
        mvalid = 1'b0;
        rst = 1'b1;
        step();
        chk_reset_vals("midrst");
        rst = 1'b0;
        repeat (5) step();
        chk("midrst_no_wen", wen_n - w0, 0);
        chk("midrst_sready", int'(sready), 1);
        do_txn(1'b0, 12'h001, 8'h00, 0, 2, 8'h5A);

        // Randomized frames against the reference memory.
        for (int t = 0; t < 40; t++) begin
            md = 1'($urandom);
            a = 12'h100 + 12'($urandom_range(7, 0));
            d = 8'($urandom);
            do_txn(md, a, d, int'($urandom_range(3, 0)), int'($urandom_range(4, 0)), ref_mem[a]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
